// File: rtl/ifetch_unit.sv
// Instruction fetch unit: drives a combinational aROM and buffers fetched words in a 2-entry FIFO toward decode.
// Optional misaligned-redirect detection is enabled by defining IFETCH_ALIGN_CHK_EN.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ROM_AW   = 10
) (
  input  logic              CLK,
  input  logic              RST_n,
  output logic [ROM_AW-1:0] address,
  input  logic [31:0]       dsalida,
  output logic [31:0]       instr,
  output logic [31:0]       instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              fetch_err
);

  typedef enum logic [1:0] {IDLE, RUN, FULL} state_t;

  state_t      state, state_nxt;
  logic [31:0] fetch_pc;
  logic [1:0]  count, count_nxt;
  logic [31:0] tail_instr, tail_pc;
  logic        push, pop, flush, misalign, err_lock;

  assign address = fetch_pc[ROM_AW+1:2];
  assign pop     = instr_valid & instr_ready;

`ifdef IFETCH_ALIGN_CHK_EN
  assign misalign = redirect_valid && (redirect_pc[1:0] != 2'b00);
  assign err_lock = fetch_err;

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n)        fetch_err <= 1'b0;
    else if (misalign) fetch_err <= 1'b1;
  end
`else
  assign misalign  = 1'b0;
  assign err_lock  = 1'b0;
  assign fetch_err = 1'b0;
`endif

  // Once a fetch error is latched the unit is parked, so later redirects are ignored.
  assign flush = redirect_valid & ~err_lock;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    // NOTE: defaults first so no path through this block leaves a signal unassigned (no latches).
    state_nxt = state;
    if (flush) begin
      state_nxt = misalign ? IDLE : RUN;
    end else begin
      case (state)
        IDLE:    if (!err_lock) state_nxt = RUN;
        RUN:     if (count_nxt == 2'd2) state_nxt = FULL;
        FULL:    if (pop) state_nxt = RUN;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    push      = (state == RUN) && !flush && ((count != 2'd2) || pop);
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + 2'd1;
      2'b01:   count_nxt = count - 2'd1;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      fetch_pc    <= RESET_PC;
      count       <= 2'd0;
      instr_valid <= 1'b0;
      instr       <= 32'd0;
      instr_pc    <= 32'd0;
    end else if (flush) begin
      fetch_pc    <= redirect_pc & 32'hFFFF_FFFC;
      count       <= 2'd0;
      instr_valid <= 1'b0;
    end else begin
      count       <= count_nxt;
      instr_valid <= (count_nxt != 2'd0);
      if (push) fetch_pc <= fetch_pc + 32'd4;
      if (pop && (count == 2'd2)) begin
        instr    <= tail_instr;
        instr_pc <= tail_pc;
      end else if (push && ((count == 2'd0) || pop)) begin
        instr    <= dsalida;
        instr_pc <= fetch_pc;
      end
    end
  end

  // NOTE: the tail entry is data-only storage qualified by count, so it needs no reset.
  always_ff @(posedge CLK) begin
    if (push && (count_nxt == 2'd2)) begin
      tail_instr <= dsalida;
      tail_pc    <= fetch_pc;
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Scoreboard bench for ifetch_unit: expected {pc, instr} pairs are queued per phase and compared on each accepted pop.
module tb_ifetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          ROM_AW   = 10;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic              CLK = 1'b0;
  logic              RST_n;
  logic [ROM_AW-1:0] address;
  logic [31:0]       dsalida;
  logic [31:0]       instr, instr_pc;
  logic              instr_valid, instr_ready;
  logic              redirect_valid;
  logic [31:0]       redirect_pc;
  logic              fetch_err;

  logic [31:0] mem [0:(1<<ROM_AW)-1];
  exp_t        exp_q[$];
  logic [31:0] next_pc;
  string       phase;
  int          n_checks = 0;
  int          n_errors = 0;

  ifetch_unit #(.RESET_PC(RESET_PC), .ROM_AW(ROM_AW)) dut (
    .CLK(CLK), .RST_n(RST_n), .address(address), .dsalida(dsalida),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .fetch_err(fetch_err)
  );

  always #5 CLK = ~CLK;
  assign dsalida = mem[address];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL [%s] %s: got %h expected %h at %0t", phase, tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] rom_word(input logic [31:0] pc);
    logic [ROM_AW-1:0] idx;
    idx = pc[ROM_AW+1:2];
    return mem[idx];
  endfunction

  task automatic push_expected(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.pc    = next_pc;
      e.instr = rom_word(next_pc);
      exp_q.push_back(e);
      next_pc = next_pc + 32'd4;
    end
  endtask

  task automatic restart_stream(input logic [31:0] pc);
    exp_q.delete();
    next_pc = pc;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Compare the head against the scoreboard whenever a real pop will occur at the coming edge.
  task automatic cycle();
    exp_t e;
    if (instr_valid && instr_ready && !redirect_valid && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("pc", instr_pc, e.pc);
      check("instr", instr, e.instr);
    end
    tick();
  endtask

  task automatic drain();
    int budget;
    int b;
    budget = 2 * exp_q.size() + 8;
    b = 0;
    while (exp_q.size() != 0 && b < budget) begin
      cycle();
      b++;
    end
    check("drain_left", exp_q.size(), 0);
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    cycle();
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < (1 << ROM_AW); i++) mem[i] = (i * 32'h9E37_79B9) ^ 32'h0F0F_0000 ^ i;
    RST_n = 1'b0; instr_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
    next_pc = RESET_PC;

    phase = "reset";
    tick(); tick();
    check("valid", instr_valid, 0);
    check("instr", instr, 0);
    check("instr_pc", instr_pc, 0);
    check("fetch_err", fetch_err, 0);
    check("address", address, RESET_PC >> 2);

    phase = "latency";
    RST_n = 1'b1; instr_ready = 1'b1;
    tick();
    check("valid_idle", instr_valid, 0);
    tick();
    check("valid_first", instr_valid, 1);

    phase = "stream";
    restart_stream(RESET_PC);
    push_expected(28);
    drain();

    phase = "stall";
    instr_ready = 1'b0;
    cycle();
    for (int i = 0; i < 5; i++) begin
      check("hold_valid", instr_valid, 1);
      check("hold_pc", instr_pc, next_pc);
      check("hold_instr", instr, rom_word(next_pc));
      check("hold_addr", address, (next_pc + 32'd8) >> 2);
      cycle();
    end
    instr_ready = 1'b1;
    push_expected(10);
    drain();

    phase = "redirect";
    instr_ready = 1'b0;
    cycle(); cycle();
    instr_ready = 1'b1;
    do_redirect(32'h40);
    check("flush_valid", instr_valid, 0);
    check("addr", address, 32'h40 >> 2);
    tick();
    check("target_valid", instr_valid, 1);
    check("target_pc", instr_pc, 32'h40);
    check("target_instr", instr, mem[16]);
    restart_stream(32'h40);
    push_expected(6);
    drain();

    phase = "wrap";
    do_redirect(32'hFF8);
    check("addr", address, 1022);
    restart_stream(32'hFF8);
    push_expected(5);
    drain();
    check("wrap_word", rom_word(32'h1000), mem[0]);

    phase = "async_reset";
    push_expected(3);
    drain();
    #2 RST_n = 1'b0;
    #1;
    check("valid_drop", instr_valid, 0);
    check("pc_clear", instr_pc, 0);
    check("addr", address, RESET_PC >> 2);
    tick();
    RST_n = 1'b1;
    restart_stream(RESET_PC);
    push_expected(4);
    drain();

    phase = "misaligned";
    do_redirect(32'h42);
`ifdef IFETCH_ALIGN_CHK_EN
    check("fetch_err", fetch_err, 1);
    for (int i = 0; i < 4; i++) begin
      check("valid_parked", instr_valid, 0);
      tick();
    end
    check("err_sticky", fetch_err, 1);
`else
    check("fetch_err", fetch_err, 0);
    check("addr", address, 32'h40 >> 2);
    restart_stream(32'h40);
    push_expected(3);
    drain();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ifetch_unit.md
IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, byte address of the first instruction fetched after reset.
REQ-002 SHALL have parameter ROM_AW, default 10, ROM word-address width.
REQ-003 SHALL have port CLK  input  1  the single clock; all state updates on rising edge.
REQ-004 SHALL have port RST_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port address  output  ROM_AW  word address driven to aROM; aROM returns dsalida combinationally in the same cycle.
REQ-006 SHALL have port dsalida  input  32  instruction word from aROM.
REQ-007 SHALL have port instr  output  32  instruction at the buffer head.
REQ-008 SHALL have port instr_pc  output  32  byte PC of instr.
REQ-009 SHALL have port instr_valid  output  1  head entry valid.
REQ-010 SHALL have port instr_ready  input  1  decode accepts head; a pop occurs when instr_valid and instr_ready.
REQ-011 SHALL have port redirect_valid  input  1  branch/jump taken this cycle.
REQ-012 SHALL have port redirect_pc  input  32  byte target of the redirect.
REQ-013 SHALL have port fetch_err  output  1  misaligned-redirect flag (see Configuration).

Function
REQ-014 SHALL hold fetch_pc (32 bits) and a 2-entry FIFO of {instr, pc} pairs; address SHALL equal fetch_pc[ROM_AW+1:2] at all times.
REQ-015 SHALL implement FSM states IDLE, RUN, FULL: IDLE -> RUN the first cycle after reset release; RUN -> FULL when count reaches 2 with no pop; FULL -> RUN on pop or redirect.
REQ-016 In RUN, a push SHALL occur every cycle: capture {dsalida, fetch_pc} into the FIFO tail and set fetch_pc <= fetch_pc + 4.
REQ-017 In IDLE or FULL no push SHALL occur; fetch_pc and address SHALL hold.
REQ-018 Push and pop in the same cycle SHALL be allowed when count is 1 (count unchanged, order preserved); at count 2 push SHALL occur only if pop occurs the same cycle.
REQ-019 Latency: an instruction addressed in cycle N SHALL appear on instr/instr_valid in cycle N+1 at the earliest.
REQ-020 Redirect SHALL take priority over push and pop: the FIFO is flushed (count 0, instr_valid 0 next cycle), fetch_pc <= redirect_pc, state <= RUN; any pop that cycle is discarded.
REQ-021 The first instruction from redirect_pc SHALL be valid two cycles after redirect_valid.
REQ-022 fetch_pc SHALL wrap modulo 2^32; address SHALL therefore wrap from 2^ROM_AW-1 to 0 without stall.
REQ-023 instr, instr_pc and instr_valid SHALL be register outputs; they SHALL hold stable while instr_valid=1 and instr_ready=0.

Reset
REQ-024 On RST_n=0, asynchronously: fetch_pc=RESET_PC, count=0, state=IDLE, instr_valid=0, instr=0, instr_pc=0, fetch_err=0.
REQ-025 Reset asserted mid-operation SHALL discard all FIFO contents; fetch SHALL restart at RESET_PC.

Configuration
REQ-026 With macro IFETCH_ALIGN_CHK_EN defined, a redirect with redirect_pc[1:0] != 0 SHALL set fetch_err=1 (sticky until reset), flush the FIFO and move to IDLE with no further fetch.
REQ-027 Without IFETCH_ALIGN_CHK_EN, fetch_err SHALL be tied 0 and redirect_pc[1:0] SHALL be ignored (treated as 00).

Verification
REQ-028 Reset release, instr_ready=1, ROM loaded with myFibo.hex: instr_pc sequence 0,4,8,... one per cycle; instr equals mem[i] for i=0..27.
REQ-029 instr_ready=0 for 5 cycles after 2 valid entries: state FULL, address frozen, instr/instr_pc unchanged; ready=1 resumes with no lost or duplicated word.
REQ-030 redirect_valid=1, redirect_pc=0x40 while 2 entries buffered: instr_valid=0 next cycle, next valid instr_pc=0x40 with instr=mem[16].
REQ-031 fetch_pc=0xFFC (ROM_AW=10): address wraps 1023 -> 0, instr_pc=0x1000 carries mem[0].
REQ-032 RST_n pulsed low mid-stream: instr_valid drops asynchronously, first post-reset instr_pc=RESET_PC.
REQ-033 With IFETCH_ALIGN_CHK_EN, redirect_pc=0x42: fetch_err=1 next cycle, instr_valid stays 0; without the macro, same stimulus fetches from 0x40.
